// File: rtl/if_stage.sv
// if_stage: ANTARES-R2 instruction fetch, PC select and IF/ID register.
// Define IF_STAGE_PERF_EN to add FetchCount/BubbleCount outputs.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        Stall,
  input  logic        IF_Flush,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] BranchTarget,
  input  logic [31:0] JumpRegTarget,
  output logic        IMem_Req,
  output logic [31:0] IMem_Addr,
  input  logic        IMem_Ready,
  input  logic [31:0] IMem_Data,
  output logic [31:0] IFID_Instruction,
  output logic [31:0] IFID_PCPlus4,
`ifdef IF_STAGE_PERF_EN
  output logic        IFID_Valid,
  output logic [31:0] FetchCount,
  output logic [31:0] BubbleCount
`else
  output logic        IFID_Valid
`endif
);

  typedef enum logic [1:0] {
    FETCH,
    BUFFERED,
    SQUASH
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] fetch_addr, fetch_addr_nxt;
  logic [31:0] buf_instr, buf_instr_nxt;
  logic [31:0] buf_pc4, buf_pc4_nxt;
  logic [31:0] ifid_instr_nxt, ifid_pc4_nxt;
  logic        ifid_valid_nxt;
  logic [31:0] pc_plus4, target;
  logic        redirect, bubble;

  assign pc_plus4 = pc + 32'd4;
  assign redirect = IFID_Valid & ~Stall & (PCSrc != 2'b00);

  // Requests are masked while reset is held and while data waits in the buffer.
  assign IMem_Req  = ~reset & (state != BUFFERED);
  assign IMem_Addr = (state == SQUASH) ? fetch_addr : pc;

  // Redirect target selection from the ID-stage control.
  always_comb begin
    target = pc_plus4;
    unique case (PCSrc)
      2'b01:   target = {IFID_PCPlus4[31:28],
                         IFID_Instruction[25:0], 2'b00};
      2'b10:   target = BranchTarget;
      2'b11:   target = JumpRegTarget;
      default: target = pc_plus4;
    endcase
  end

  // Next-state and datapath update for the fetch FSM.
  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    fetch_addr_nxt = fetch_addr;
    buf_instr_nxt  = buf_instr;
    buf_pc4_nxt    = buf_pc4;
    ifid_instr_nxt = IFID_Instruction;
    ifid_pc4_nxt   = IFID_PCPlus4;
    ifid_valid_nxt = IFID_Valid;
    bubble         = 1'b0;
    unique case (state)
      FETCH: begin
        if (redirect) begin
          bubble = 1'b1;
          pc_nxt = target;
          if (!IMem_Ready) begin
            state_nxt      = SQUASH;
            fetch_addr_nxt = pc;
          end
        end else if (IMem_Ready && !Stall) begin
          pc_nxt = pc_plus4;
          if (IF_Flush) begin
            bubble = 1'b1;
          end else begin
            ifid_instr_nxt = IMem_Data;
            ifid_pc4_nxt   = pc_plus4;
            ifid_valid_nxt = 1'b1;
          end
        end else if (IMem_Ready) begin
          buf_instr_nxt = IMem_Data;
          buf_pc4_nxt   = pc_plus4;
          pc_nxt        = pc_plus4;
          state_nxt     = BUFFERED;
        end else if (!Stall) begin
          bubble = 1'b1;
        end
      end
      BUFFERED: begin
        if (redirect) begin
          bubble    = 1'b1;
          pc_nxt    = target;
          state_nxt = FETCH;
        end else if (!Stall) begin
          state_nxt = FETCH;
          if (IF_Flush) begin
            bubble = 1'b1;
          end else begin
            ifid_instr_nxt = buf_instr;
            ifid_pc4_nxt   = buf_pc4;
            ifid_valid_nxt = 1'b1;
          end
        end
      end
      SQUASH: begin
        if (IMem_Ready) state_nxt = FETCH;
        if (!Stall) bubble = 1'b1;
      end
      default: state_nxt = FETCH;
    endcase
    if (bubble) begin
      ifid_instr_nxt = 32'h0;
      ifid_pc4_nxt   = 32'h0;
      ifid_valid_nxt = 1'b0;
    end
  end

  // State, PC, holding buffer and IF/ID register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= FETCH;
      pc               <= RESET_PC;
      fetch_addr       <= RESET_PC;
      buf_instr        <= 32'h0;
      buf_pc4          <= 32'h0;
      IFID_Instruction <= 32'h0;
      IFID_PCPlus4     <= 32'h0;
      IFID_Valid       <= 1'b0;
    end else begin
      state            <= state_nxt;
      pc               <= pc_nxt;
      fetch_addr       <= fetch_addr_nxt;
      buf_instr        <= buf_instr_nxt;
      buf_pc4          <= buf_pc4_nxt;
      IFID_Instruction <= ifid_instr_nxt;
      IFID_PCPlus4     <= ifid_pc4_nxt;
      IFID_Valid       <= ifid_valid_nxt;
    end
  end

`ifdef IF_STAGE_PERF_EN
  // Free-running fetch and bubble counters, wrapping at 2^32.
  always_ff @(posedge clock) begin
    if (reset) begin
      FetchCount  <= 32'h0;
      BubbleCount <= 32'h0;
    end else begin
      if (state == FETCH && IMem_Ready)
        FetchCount <= FetchCount + 32'd1;
      if (bubble)
        BubbleCount <= BubbleCount + 32'd1;
    end
  end
`endif

endmodule
